// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 LSB-first UART receiver that packs four consecutive bytes
// into a 32-bit word (first byte in [7:0]). The output is a valid/ready word
// interface with one-cycle frame-error and overrun pulses.
module uart_rx_word #(
  parameter int CLK_PER_HALF_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic        rx_busy,
  output logic        ferr,
  output logic        overrun
);

  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int CW       = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          r_sync1;
  logic          r_rxs;
  logic          r_rxs_prev;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [1:0]    r_idx;
  logic [31:0]   r_word;
  logic          r_done;
  logic          r_ferr;
  logic [31:0]   r_rdata;
  logic          r_valid;
  logic          r_overrun;

  logic          w_start_edge;
  logic          w_accept;

  assign w_start_edge = !r_rxs && r_rxs_prev;
  assign w_accept     = r_valid && rdata_ready;

  // Two-flop synchronizer for the asynchronous line plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the synchronizer resets to the idle-line level so leaving reset never fakes a start edge.
      r_sync1    <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop take the previous stage's old value, forming a real chain.
      r_sync1    <= rxd;
      r_rxs      <= r_sync1;
      r_rxs_prev <= r_rxs;
    end
  end

  // Frame FSM: start qualification, mid-bit data sampling, stop check and byte packing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_idx     <= '0;
      r_word    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            // A line already back high at mid start bit was a glitch.
            r_state   <= r_rxs ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_rxs, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == BIT_LAST) begin
            // Leave at mid stop bit so a shortened stop bit from the sender is tolerated.
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (r_rxs) begin
              r_word[8*r_idx +: 8] <= r_shift;
              r_idx                <= r_idx + 2'd1;
              r_done               <= (r_idx == 2'd3);
            end else begin
              // Bad framing: drop the byte and realign to a word boundary.
              r_ferr <= 1'b1;
              r_idx  <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output word register and handshake; an accept in the completion cycle frees the slot first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (!r_valid || w_accept) begin
          r_rdata <= r_word;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_valid;
  assign ferr        = r_ferr;
  assign overrun     = r_overrun;
  assign rx_busy     = (r_state != S_IDLE) || (r_idx != 2'd0);

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- UART receiver, 8N1, LSB-first.
- Assembles four consecutive bytes into one 32-bit word: first byte received goes to bits [7:0], fourth byte to bits [31:24].
- It is the receive-side counterpart of the team's 4-byte word transmitter and sits between the board RX pin and the core's input port.
- Output is a valid/ready word interface with frame-error and overrun reporting.

Parameters:
- CLK_PER_HALF_BIT, default 434, clock cycles per half bit period. Bit period is 2*CLK_PER_HALF_BIT. Legal range is 2 or more.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rxd  input  1  serial line, asynchronous, idle high.
- rdata  output  32  received word.
- rdata_valid  output  1  rdata holds an unconsumed word.
- rdata_ready  input  1  consumer accepts rdata this cycle.
- rx_busy  output  1  a byte frame is in progress, or bytes 1..3 of a word have been received.
- ferr  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a word completed while rdata_valid was high.

Behaviour:
- Reset (rst high at a clk edge): every output is 0.
  - State goes to IDLE; byte index, counter and shift register clear.
  - Synchronizer flops load 1.
  - Reset takes effect mid-frame and discards any partial word.
- Input path: rxd passes through a 2-flop synchronizer to give rxs. Start detection uses rxs falling, i.e. rxs==0 with the previous rxs==1.
- State machine, with a bit counter running 0..N:
  - IDLE: on a start edge, go to START and clear the counter.
  - START: at counter == CLK_PER_HALF_BIT-1 (mid start bit), sample rxs.
    - rxs==1: false start, return to IDLE. Nothing is reported.
    - rxs==0: go to DATA with bit count 0 and clear the counter.
  - DATA: at counter == 2*CLK_PER_HALF_BIT-1, sample rxs into shift register bit 7 and shift right.
    - After the 8th sample, go to STOP.
  - STOP: at counter == 2*CLK_PER_HALF_BIT-1, sample rxs, then return to IDLE the same cycle.
    - rxs==1: the byte is accepted and written to word byte [idx]; idx increments.
    - rxs==0: ferr pulses for 1 cycle, the byte is dropped, and idx resets to 0 (realign to a word boundary).
- Because STOP returns to IDLE at mid stop bit, a start edge one half bit later is accepted. This tolerates the transmitter's shortened (0.9-bit) stop bit.
- Word completion: when the byte with idx==3 is accepted, idx wraps to 0.
  - If rdata_valid==0: rdata loads the full word and rdata_valid rises on the next cycle edge. Latency is 1 cycle after the stop-bit sample.
  - If rdata_valid==1: rdata is left unchanged, the new word is dropped, and overrun pulses for 1 cycle.
- Handshake:
  - rdata_valid stays high and rdata stays stable until a cycle with rdata_ready==1; rdata_valid clears on the next edge.
  - If an accept and a completion happen in the same cycle, the accept wins first: the new word loads, rdata_valid stays 1, and there is no overrun.
  - rdata_ready while rdata_valid==0 is ignored.
- rx_busy = (state != IDLE) || (idx != 0).
- Noise: rxd changes while in DATA/STOP outside the sample points are ignored. Only the single mid-bit sample counts; there is no majority vote.
- The counter width is ceil(log2(2*CLK_PER_HALF_BIT)). It must not wrap inside any state.

Test Plan (CLK_PER_HALF_BIT=4, bit = 8 clk):
- Send bytes EF, BE, AD, DE with rdata_ready=0 → rdata_valid rises 1 cycle after the 4th stop-bit sample, rdata=0xDEADBEEF, ferr=0, overrun=0. Then pulse rdata_ready for 1 cycle → rdata_valid falls next edge.
- Drive rxd low for 2 clk, then high (glitch) → returns to IDLE; no ferr, rx_busy back to 0; a following word 0x12345678 is received correctly.
- Send bytes 11, 22, then 33 with the stop bit held low → ferr pulses 1 cycle at the stop sample, idx=0. Then bytes 44, 55, 66, 77 → rdata=0x77665544.
- Receive 0xA5A5A5A5, keep rdata_ready=0, and send 0x01020304 → overrun pulses once, rdata still 0xA5A5A5A5. Then hold rdata_ready=1 and send 0xCAFEF00D with an accept coinciding with completion → rdata=0xCAFEF00D, no overrun.
- Assert rst for 1 cycle during bit 3 of byte 2 → all outputs 0 next cycle. A subsequent full word 0x0BADC0DE is received intact.
- Back-to-back frames: stop bit lasts 0.9 bit (7 clk) before the next start bit → all four bytes accepted, rdata=0x89ABCDEF.
